// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - time/clock conversion helpers and timer state type
package time_pkg;

    typedef enum logic {TMR_IDLE, TMR_RUN} timer_state_t;

    // Clock cycles covering time_ns at freq_mhz, rounded up so a delay is never short.
    function automatic int nb_clk_for_time(input int freq_mhz, input int time_ns);
        return (freq_mhz * time_ns + 999) / 1000;
    endfunction

    function automatic int clks_per_us(input int freq_mz);
        return nb_clk_for_time(freq_mz, 1000);
    endfunction

endpackage

// File: rtl/us_delay_timer_tick_prescaler.sv
// rtl/us_delay_timer_tick_prescaler.sv - 0..DIV-1 counter; tick marks the wrapping clock
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    // clr restarts the period with the clearing edge already counted as its first clock
    localparam logic [CNT_W-1:0] RESTART = (DIV > 1) ? CNT_W'(1) : '0;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= RESTART;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/us_delay_timer.sv
// rtl/us_delay_timer.sv - free-running us/ms timebase and retriggerable one-shot in us
module us_delay_timer
    import time_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int DELAY_W      = 16,
    parameter int MS_DIV       = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay_us,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [DELAY_W-1:0] remaining_us,
    output logic               tick_us,
    output logic               tick_ms
);
    localparam int CLKS_PER_US = clks_per_us(CLK_FREQ_MHZ);
    // With one clock per us the load edge itself completes the first us.
    localparam logic [DELAY_W-1:0] LOAD_DEC = (CLKS_PER_US == 1) ? DELAY_W'(1) : '0;

    generate
        if (CLKS_PER_US < 1 || MS_DIV < 1) begin : g_bad_param
            $error("us_delay_timer: CLKS_PER_US and MS_DIV must be at least 1");
        end
    endgenerate

    timer_state_t state;
    logic         us_wrap;
    logic         ms_wrap;
    logic         os_wrap;
    logic         load;

    assign load = start && !abort;
    assign busy = (state == TMR_RUN);

    tick_prescaler #(.DIV(CLKS_PER_US)) u_us_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (1'b1),
        .tick (us_wrap)
    );

    tick_prescaler #(.DIV(MS_DIV)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (us_wrap),
        .tick (ms_wrap)
    );

    tick_prescaler #(.DIV(CLKS_PER_US)) u_os_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (busy),
        .tick (os_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= TMR_IDLE;
            remaining_us <= '0;
            done         <= 1'b0;
            tick_us      <= 1'b0;
            tick_ms      <= 1'b0;
        end else begin
            tick_us <= us_wrap;
            tick_ms <= ms_wrap;
            done    <= 1'b0;
            // abort beats start, and both beat the expiry of the current run
            if (abort) begin
                state        <= TMR_IDLE;
                remaining_us <= '0;
            end else if (start) begin
                if (delay_us == '0 || delay_us == LOAD_DEC) begin
                    state        <= TMR_IDLE;
                    remaining_us <= '0;
                    done         <= 1'b1;
                end else begin
                    state        <= TMR_RUN;
                    remaining_us <= delay_us - LOAD_DEC;
                end
            end else if (busy && os_wrap) begin
                if (remaining_us == DELAY_W'(1)) begin
                    state        <= TMR_IDLE;
                    remaining_us <= '0;
                    done         <= 1'b1;
                end else begin
                    remaining_us <= remaining_us - DELAY_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_us_delay_timer.sv
// tb/tb_us_delay_timer.sv - directed checks of us_delay_timer at 10 MHz, MS_DIV=1000
module tb_us_delay_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] delay_us;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] remaining_us;
    logic        tick_us;
    logic        tick_ms;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_at = -1;

    us_delay_timer #(
        .CLK_FREQ_MHZ (10),
        .DELAY_W      (16),
        .MS_DIV       (1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .delay_us     (delay_us),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .remaining_us (remaining_us),
        .tick_us      (tick_us),
        .tick_ms      (tick_ms)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int k;
    int d0;
    int bad_us;
    int bad_ms;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        delay_us = '0;
        abort = 1'b0;
        step(3);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rem", remaining_us, 0);
        chk("reset_tick_us", tick_us, 0);
        chk("reset_tick_ms", tick_ms, 0);

        // timebase from release: tick_us every 10 cycles, tick_ms at cycle 10000
        rst = 1'b0;
        cyc = 0;
        bad_us = 0;
        bad_ms = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1);
            if (tick_us !== ((cyc % 10) == 0)) bad_us++;
            if (tick_ms !== (cyc == 10000)) bad_ms++;
        end
        chk("tick_us_pattern", bad_us, 0);
        chk("tick_ms_pattern", bad_ms, 0);
        chk("tick_ms_at_10000", tick_ms, 1);
        chk("tick_us_at_10000", tick_us, 1);
        step(1);
        chk("tick_ms_after", tick_ms, 0);

        // one-shot of 3 us
        k = cyc;
        d0 = done_cnt;
        start = 1'b1;
        delay_us = 16'd3;
        step(1);
        start = 1'b0;
        chk("d3_busy_k1", busy, 1);
        chk("d3_rem_k1", remaining_us, 3);
        step(8);
        chk("d3_rem_k9", remaining_us, 3);
        step(1);
        chk("d3_rem_k10", remaining_us, 2);
        step(10);
        chk("d3_rem_k20", remaining_us, 1);
        step(9);
        chk("d3_busy_k29", busy, 1);
        chk("d3_done_k29", done, 0);
        step(1);
        chk("d3_done_k30", done, 1);
        chk("d3_busy_k30", busy, 0);
        chk("d3_rem_k30", remaining_us, 0);
        step(1);
        chk("d3_done_k31", done, 0);
        chk("d3_done_count", done_cnt - d0, 1);
        chk("d3_done_cycle", done_at, k + 30);

        // zero delay
        k = cyc;
        d0 = done_cnt;
        start = 1'b1;
        delay_us = 16'd0;
        step(1);
        start = 1'b0;
        chk("d0_done_k1", done, 1);
        chk("d0_busy_k1", busy, 0);
        chk("d0_rem_k1", remaining_us, 0);
        step(1);
        chk("d0_done_k2", done, 0);
        chk("d0_done_count", done_cnt - d0, 1);

        // retrigger: 5 us at k, 2 us at k+17
        k = cyc;
        d0 = done_cnt;
        start = 1'b1;
        delay_us = 16'd5;
        step(1);
        start = 1'b0;
        step(16);
        chk("rt_rem_k17", remaining_us, 4);
        start = 1'b1;
        delay_us = 16'd2;
        step(1);
        start = 1'b0;
        chk("rt_rem_k18", remaining_us, 2);
        chk("rt_busy_k18", busy, 1);
        step(18);
        chk("rt_rem_k36", remaining_us, 1);
        chk("rt_done_k36", done, 0);
        step(1);
        chk("rt_done_k37", done, 1);
        step(20);
        chk("rt_done_count", done_cnt - d0, 1);
        chk("rt_done_cycle", done_at, k + 37);

        // abort while running
        d0 = done_cnt;
        start = 1'b1;
        delay_us = 16'd4;
        step(1);
        start = 1'b0;
        step(14);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ab_busy_k16", busy, 0);
        chk("ab_rem_k16", remaining_us, 0);
        step(40);
        chk("ab_no_done", done_cnt - d0, 0);

        // abort together with start in IDLE
        abort = 1'b1;
        start = 1'b1;
        delay_us = 16'd7;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abst_busy", busy, 0);
        chk("abst_rem", remaining_us, 0);
        step(2);
        chk("abst_no_done", done_cnt - d0, 0);

        // abort on the final-us wrap edge suppresses done
        start = 1'b1;
        delay_us = 16'd1;
        step(1);
        start = 1'b0;
        step(8);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("coll_busy", busy, 0);
        step(5);
        chk("coll_no_done", done_cnt - d0, 0);

        // reset in the middle of a run
        k = cyc;
        start = 1'b1;
        delay_us = 16'd3;
        step(1);
        start = 1'b0;
        step(11);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rs_busy_k13", busy, 0);
        chk("rs_rem_k13", remaining_us, 0);
        chk("rs_tick_us_k13", tick_us, 0);
        chk("rs_tick_ms_k13", tick_ms, 0);
        step(9);
        chk("rs_tick_us_k22", tick_us, 0);
        step(1);
        chk("rs_tick_us_k23", tick_us, 1);
        step(30);
        chk("rs_no_done", done_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/us_delay_timer.md
Name: us_delay_timer

Overview:
- Cycle-accurate delay and timebase stage that consumes the time_pkg conversion helpers.
- CLK_FREQ_MHZ is turned into a clocks-per-microsecond divisor at elaboration.
- Provides free-running µs/ms tick strobes plus a retriggerable one-shot timer programmed in microseconds.
- Sits between control FSMs (reset sequencers, link-up waits, watchdogs) and the clock domain they run in.

Parameters:
CLK_FREQ_MHZ, 100, clock frequency in MHz; CLKS_PER_US = time_pkg::nb_clk_for_time(CLK_FREQ_MHZ, 1000)
DELAY_W, 16, width of delay_us / remaining_us (max delay 2^DELAY_W-1 µs)
MS_DIV, 1000, tick_us pulses per tick_ms pulse

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  load delay_us and (re)start one-shot; sampled each rising edge
delay_us  in  DELAY_W  delay in µs, sampled only when start accepted
abort  in  1  cancel running one-shot, no done
busy  out  1  one-shot running
done  out  1  single-cycle pulse at expiry
remaining_us  out  DELAY_W  whole µs left; 0 when idle
tick_us  out  1  free-running 1-cycle pulse every CLKS_PER_US cycles
tick_ms  out  1  1-cycle pulse coincident with every MS_DIV-th tick_us

Behaviour:
- Clocking and reset: one clock domain; reset synchronous, active-high. While rst=1 at an edge, all outputs are 0 on the next cycle, all counters clear, and the FSM goes to IDLE.
- Elaboration check: $error if CLKS_PER_US < 1 or MS_DIV < 1.
- Free-running timebase:
  - µs prescaler counts 0..CLKS_PER_US-1. tick_us=1 in the cycle the count wraps.
  - First tick_us is in cycle CLKS_PER_US after the first edge with rst=0.
  - ms counter counts tick_us pulses 0..MS_DIV-1. tick_ms=1 together with the wrapping tick_us.
  - Independent of the one-shot; never cleared by start or abort.
- One-shot FSM states: IDLE, RUN.
  - IDLE, start=1, abort=0, delay_us=0: done=1 next cycle; stay IDLE; busy stays 0.
  - IDLE, start=1, abort=0, delay_us>0: go to RUN; load remaining_us=delay_us; clear the one-shot prescaler (separate from the free-running one).
  - RUN: one-shot prescaler counts CLKS_PER_US cycles per µs; remaining_us decrements on each wrap.
  - RUN, wrap that takes remaining_us 1->0: go to IDLE. In that cycle busy=0 and done=1.
- Timing: start sampled at edge k with delay D>0 gives:
  - busy=1 in cycles k+1..k+D*CLKS_PER_US-1;
  - done=1 in cycle k+D*CLKS_PER_US only;
  - remaining_us=D from k+1, decrementing every CLKS_PER_US cycles.
- Retrigger: start in RUN reloads remaining_us with the new delay_us and clears the prescaler. Timing restarts from that edge exactly as in IDLE. The old expiry never fires. Retrigger with delay_us=0 gives done next cycle and IDLE.
- Abort: abort=1 in RUN gives IDLE next cycle with busy=0, remaining_us=0 and no done.
  - abort together with start: abort wins; start is ignored.
  - abort in IDLE: no effect.
- Expiry collision: if start or abort coincides with the final-µs wrap edge, start/abort takes priority and done is not asserted for the old run.
- Widths and arithmetic: no D*CLKS_PER_US product is formed; the count is kept in µs units.
  - Prescaler width: $clog2(CLKS_PER_US+1).
  - ms counter width: $clog2(MS_DIV+1).
- Registering: all outputs are registered; no combinational input-to-output path.

Decomposition:
- time_pkg gets:
  - the typedef enum logic {TMR_IDLE, TMR_RUN} timer_state_t;
  - the helper function clks_per_us(freq_mz), returning nb_clk_for_time(freq_mz, 1000).
- Sub-module tick_prescaler:
  - parameter DIV; inputs clk, rst, clr, en; output tick;
  - a 0..DIV-1 counter with synchronous clear.
  - Instantiated for the free µs tick, the ms tick (en=tick_us, DIV=MS_DIV) and the one-shot µs tick (clr=load).

Test Plan:
- Tests run with CLK_FREQ_MHZ=10 (CLKS_PER_US=10) and MS_DIV=1000.
- rst released at edge 0 -> tick_us in cycles 10, 20, 30…; first tick_ms in cycle 10000 coincident with tick_us; no other pulses.
- start, delay_us=3 at edge k -> busy=1 in cycles k+1..k+29; done single pulse at k+30; remaining_us 3/2/1 changing at k+10/k+20; 0 at k+30.
- start, delay_us=0 at k -> done=1 at k+1 only; busy never 1; remaining_us stays 0.
- start with delay 5 at k, then start with delay 2 at k+17 -> exactly one done, at k+37; remaining_us reloads to 2 at k+18.
- start with delay 4 at k, abort at k+15 -> busy=0 and remaining_us=0 at k+16, no done ever; abort+start at the same edge in IDLE -> stays IDLE, no done.
- start with delay 3 at k, rst=1 at edge k+12 -> all outputs 0 at k+13, no done; after release, tick_us first appears 10 cycles later.
